// File: rtl/ysyx_22040632_mul_wallace_pipe.sv
// ysyx_22040632_mul_wallace_pipe: pipelined radix-4 Booth / Wallace-tree multiplier; YSYX_22040632_MUL_WORD_OP_EN adds RV64 word ops
module ysyx_22040632_mul_wallace_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
`ifdef YSYX_22040632_MUL_WORD_OP_EN
    input  logic             in_word,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH / 2 + 2;
    localparam int RW = NR * PW;

    typedef struct packed {
        logic             v;
        logic             wd;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [RW-1:0]    rows;
    } st_t;

    // number of live rows entering tree level l
    function automatic int rows_at(input int l);
        int n;
        n = NR;
        for (int i = 0; i < NR; i++) if (i < l) n = n - n / 3;
        return n;
    endfunction

    function automatic int num_levels(input int rows);
        int n, c;
        n = rows;
        c = 0;
        for (int i = 0; i < NR; i++) if (n > 2) begin
            n = n - n / 3;
            c++;
        end
        return c;
    endfunction

    localparam int NLEV = num_levels(NR);

    // last tree level (exclusive) finished by stage s; first stage owns level 0 only
    function automatic int lvl_hi(input int s);
        return (s >= PIPE_STAGES) ? NLEV : (s == 1) ? 1 : 1 + (NLEV - 1) * (s - 1) / (PIPE_STAGES - 1);
    endfunction

    // one Wallace level: groups of three rows become sum + shifted carry, leftovers pass through
    function automatic logic [RW-1:0] csa_level(input logic [RW-1:0] r, input int n);
        logic [RW-1:0] o;
        logic [PW-1:0] x, y, z;
        int g;
        o = '0;
        g = n / 3;
        for (int i = 0; i < NR / 3; i++) if (i < g) begin
            x = r[3*i*PW +: PW];
            y = r[(3*i+1)*PW +: PW];
            z = r[(3*i+2)*PW +: PW];
            o[2*i*PW +: PW] = x ^ y ^ z;
            o[(2*i+1)*PW +: PW] = ((x & y) | (x & z) | (y & z)) << 1;
        end
        for (int j = 0; j < NR; j++) if (j >= 3 * g && j < n) o[(j-g)*PW +: PW] = r[j*PW +: PW];
        return o;
    endfunction

    function automatic logic [RW-1:0] reduce(input logic [RW-1:0] r, input int lo, input int hi);
        logic [RW-1:0] t;
        t = r;
        for (int l = 0; l < NLEV; l++) if (l >= lo && l < hi) t = csa_level(t, rows_at(l));
        return t;
    endfunction

    // radix-4 Booth rows; the last row carries the +1 of every negated partial product
    function automatic logic [RW-1:0] booth(input logic [WIDTH+1:0] ax, input logic [WIDTH+1:0] bx);
        logic [RW-1:0] o;
        logic [PW-1:0] a1, a2, m, neg_row;
        logic [WIDTH+2:0] bb;
        logic [2:0] trip;
        o = '0;
        neg_row = '0;
        a1 = {{(PW-WIDTH-2){ax[WIDTH+1]}}, ax};
        a2 = a1 << 1;
        bb = {bx, 1'b0};
        for (int i = 0; i <= WIDTH / 2; i++) begin
            trip = bb[2*i +: 3];
            m = (trip == 3'b011 || trip == 3'b100) ? a2 : (trip == 3'b000 || trip == 3'b111) ? '0 : a1;
            o[i*PW +: PW] = (trip[2] ? ~m : m) << (2 * i);
            neg_row[2*i] = trip[2];
        end
        o[(NR-1)*PW +: PW] = neg_row;
        return o;
    endfunction

    // operand extension per op (word ops narrow to the sign-extended low half) then Booth
    function automatic logic [RW-1:0] stage_in(input st_t x);
        logic [WIDTH-1:0] a, b;
        logic sa, sb;
        a = x.rows[WIDTH-1:0];
        b = x.rows[PW-1:WIDTH];
        if (x.wd) begin
            a = {{(WIDTH/2){a[WIDTH/2-1]}}, a[WIDTH/2-1:0]};
            b = {{(WIDTH/2){b[WIDTH/2-1]}}, b[WIDTH/2-1:0]};
        end
        sa = x.op != 2'b11;
        sb = !x.op[1];
        return booth({{2{sa & a[WIDTH-1]}}, a}, {{2{sb & b[WIDTH-1]}}, b});
    endfunction

    function automatic logic [RW-1:0] step(input st_t x, input int s);
        return (s == 1) ? reduce(stage_in(x), 0, lvl_hi(1)) : reduce(x.rows, lvl_hi(s - 1), lvl_hi(s));
    endfunction

    function automatic logic [PW-1:0] cpa(input st_t x);
        logic [RW-1:0] t;
        t = step(x, PIPE_STAGES);
        return t[PW-1:0] + t[2*PW-1:PW];
    endfunction

    logic             word;
    logic             stall;
    logic [PW-1:0]    prod;
    st_t              tail;
    st_t              st_q [PIPE_STAGES];
    st_t              st_d [PIPE_STAGES];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

`ifdef YSYX_22040632_MUL_WORD_OP_EN
    assign word = in_word;
`else
    assign word = 1'b0;
`endif

    // global stall: everything advances together unless the output is held by the consumer
    always_comb begin
        stall = out_valid_q && !out_ready;
        in_ready = !stall && !flush;
        st_d = st_q;
        tail = st_q[PIPE_STAGES-1];
        prod = cpa(tail);
        out_valid_d = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d = out_tag_q;
        if (!stall) begin
            st_d[0].v = in_valid;
            st_d[0].wd = word;
            st_d[0].op = in_op;
            st_d[0].tag = in_tag;
            st_d[0].rows = RW'({in_b, in_a});
            for (int s = 1; s < PIPE_STAGES; s++) begin
                st_d[s] = st_q[s-1];
                st_d[s].rows = step(st_q[s-1], s);
            end
            out_valid_d = tail.v;
            if (tail.v) begin
                out_tag_d = tail.tag;
                out_result_d = tail.wd ? {{(WIDTH/2){prod[WIDTH/2-1]}}, prod[WIDTH/2-1:0]}
                             : (tail.op == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
            end
        end
        if (flush) begin
            for (int s = 0; s < PIPE_STAGES; s++) st_d[s].v = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // pipeline and output registers; reset drops every op and zeroes the visible output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) st_q[s].v <= 1'b0;
            out_valid_q <= 1'b0;
            out_result_q <= '0;
            out_tag_q <= '0;
        end else begin
            st_q <= st_d;
            out_valid_q <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_ysyx_22040632_mul_wallace_pipe.sv
// tb_ysyx_22040632_mul_wallace_pipe: directed self-checking bench for the pipelined multiplier
module tb_ysyx_22040632_mul_wallace_pipe;

`ifdef YSYX_22040632_MUL_WORD_OP_EN
    localparam int W = 64;
`else
    localparam int W = 32;
`endif
    localparam int P = 2;
    localparam int TAG_W = 5;

    logic             clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]       in_op;
    logic [W-1:0]     in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;
`ifdef YSYX_22040632_MUL_WORD_OP_EN
    logic             in_word;
`endif
    int checks = 0;
    int failures = 0;

    ysyx_22040632_mul_wallace_pipe #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
`ifdef YSYX_22040632_MUL_WORD_OP_EN
        .in_word(in_word),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue one op with out_ready high and wait (bounded) for its result; lat=-1 on timeout
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TAG_W-1:0] tag, output logic [W-1:0] res,
                          output logic [TAG_W-1:0] tg, output int lat);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        tick();
        in_valid = 1'b0;
        lat = -1;
        res = '0;
        tg = '0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (out_valid) begin
                lat = i;
                res = out_result;
                tg = out_tag;
            end else tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
        checks++; if (out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%h exp=1", in_ready); end
    endtask

    task automatic test_mul;
        logic [W-1:0] b, e, res;
        logic [TAG_W-1:0] tg;
        int lat;
        b = '1;
        b[1] = 1'b0;
        e = '1 - 20;
        run_op(2'b00, W'(7), b, 5'd3, res, tg, lat);
        checks++; if (res !== e) begin failures++; $display("FAIL mul_result got=%h exp=%h", res, e); end
        checks++; if (tg !== 5'd3) begin failures++; $display("FAIL mul_tag got=%h exp=3", tg); end
        checks++; if (lat != P) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, P); end
    endtask

    task automatic test_high;
        logic [1:0] vo [15];
        logic [W-1:0] va [15], vb [15], ve [15];
        logic [W-1:0] ones, msb, qtr, maxp, res;
        logic [TAG_W-1:0] tg;
        int lat;
        ones = '1;
        msb = '0;
        msb[W-1] = 1'b1;
        qtr = msb >> 1;
        maxp = ~msb;
        vo[0]  = 2'b01; va[0]  = msb;      vb[0]  = msb;     ve[0]  = qtr;
        vo[1]  = 2'b11; va[1]  = msb;      vb[1]  = msb;     ve[1]  = qtr;
        vo[2]  = 2'b10; va[2]  = ones;     vb[2]  = ones;    ve[2]  = ones;
        vo[3]  = 2'b11; va[3]  = ones;     vb[3]  = ones;    ve[3]  = ones - 1;
        vo[4]  = 2'b01; va[4]  = ones;     vb[4]  = ones;    ve[4]  = '0;
        vo[5]  = 2'b00; va[5]  = ones;     vb[5]  = W'(5);   ve[5]  = ones - 4;
        vo[6]  = 2'b11; va[6]  = ones;     vb[6]  = W'(2);   ve[6]  = W'(1);
        vo[7]  = 2'b10; va[7]  = ones - 1; vb[7]  = ones;    ve[7]  = ones - 1;
        vo[8]  = 2'b00; va[8]  = msb;      vb[8]  = W'(2);   ve[8]  = '0;
        vo[9]  = 2'b01; va[9]  = msb;      vb[9]  = W'(1);   ve[9]  = ones;
        vo[10] = 2'b11; va[10] = msb;      vb[10] = W'(1);   ve[10] = '0;
        vo[11] = 2'b01; va[11] = maxp;     vb[11] = maxp;    ve[11] = qtr - 1;
        vo[12] = 2'b00; va[12] = maxp;     vb[12] = maxp;    ve[12] = W'(1);
        vo[13] = 2'b10; va[13] = W'(1);    vb[13] = ones;    ve[13] = '0;
        vo[14] = 2'b10; va[14] = msb;      vb[14] = msb;     ve[14] = msb | qtr;
        for (int i = 0; i < 15; i++) begin
            run_op(vo[i], va[i], vb[i], TAG_W'(i), res, tg, lat);
            checks++; if (res !== ve[i]) begin failures++; $display("FAIL high_vec%0d_result got=%h exp=%h", i, res, ve[i]); end
            checks++; if (lat != P || tg !== TAG_W'(i)) begin failures++; $display("FAIL high_vec%0d_lat_tag got=%0d/%h exp=%0d/%h", i, lat, tg, P, TAG_W'(i)); end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_op = 2'b00;
            in_a = W'(i);
            in_b = W'(i + 10);
            in_tag = TAG_W'(i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_issue%0d_in_ready got=%h exp=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready got=%h exp=0", in_ready); end
        checks++; if ({out_valid, out_tag, out_result} !== {1'b1, 5'd1, W'(11)}) begin failures++; $display("FAIL b2b_first got=%h/%h/%h exp=1/1/b", out_valid, out_tag, out_result); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({out_valid, out_tag, out_result} !== {1'b1, 5'd1, W'(11)}) begin failures++; $display("FAIL b2b_hold%0d got=%h/%h/%h exp=1/1/b", i, out_valid, out_tag, out_result); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, out_tag, out_result} !== {1'b1, 5'd2, W'(24)}) begin failures++; $display("FAIL b2b_second got=%h/%h/%h exp=1/2/18", out_valid, out_tag, out_result); end
        tick();
        checks++; if ({out_valid, out_tag, out_result} !== {1'b1, 5'd3, W'(39)}) begin failures++; $display("FAIL b2b_third got=%h/%h/%h exp=1/3/27", out_valid, out_tag, out_result); end
        tick();
        checks++; if ({out_valid, out_result} !== {1'b0, W'(39)}) begin failures++; $display("FAIL b2b_drain_hold got=%h/%h exp=0/27", out_valid, out_result); end
    endtask

    task automatic test_flush;
        logic [W-1:0] res;
        logic [TAG_W-1:0] tg;
        int lat;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_op = 2'b00; in_a = W'(2); in_b = W'(3); in_tag = 5'd4;
        tick();
        in_tag = 5'd5; in_a = W'(6);
        tick();
        flush = 1'b1;
        in_tag = 5'd6; in_a = W'(4); in_b = W'(4);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%h exp=0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i <= P; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid%0d got=%h exp=0", i, out_valid); end
            tick();
        end
        run_op(2'b00, W'(3), W'(5), 5'd9, res, tg, lat);
        checks++; if (res !== W'(15) || tg !== 5'd9) begin failures++; $display("FAIL flush_after_op got=%h/%h exp=f/9", res, tg); end
        checks++; if (lat != P) begin failures++; $display("FAIL flush_after_latency got=%0d exp=%0d", lat, P); end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; in_op = 2'b00; in_a = W'(2); in_b = W'(2); in_tag = 5'd7;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_tag, out_result} !== {1'b0, 5'd9, W'(15)}) begin failures++; $display("FAIL rstmid_held got=%h/%h/%h exp=0/9/f", out_valid, out_tag, out_result); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({out_valid, out_tag, out_result} !== '0) begin failures++; $display("FAIL rstmid_cleared got=%h/%h/%h exp=0/0/0", out_valid, out_tag, out_result); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale%0d got=%h exp=0", i, out_valid); end
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%h exp=1", in_ready); end
    endtask

`ifdef YSYX_22040632_MUL_WORD_OP_EN
    task automatic test_word;
        logic [W-1:0] va [4], vb [4], ve [4], res;
        logic [TAG_W-1:0] tg;
        int lat;
        va[0] = 64'h0000000000010000; vb[0] = 64'h0000000000010000; ve[0] = 64'h0000000000000000;
        va[1] = 64'h000000007FFFFFFF; vb[1] = 64'h0000000000000002; ve[1] = 64'hFFFFFFFFFFFFFFFE;
        va[2] = 64'hDEADBEEF00000003; vb[2] = 64'h12345678FFFFFFFF; ve[2] = 64'hFFFFFFFFFFFFFFFD;
        va[3] = 64'hFFFFFFFF00000006; vb[3] = 64'h0000000100000007; ve[3] = 64'h000000000000002A;
        in_word = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b00, va[i], vb[i], TAG_W'(i + 20), res, tg, lat);
            checks++; if (res !== ve[i]) begin failures++; $display("FAIL word_vec%0d got=%h exp=%h", i, res, ve[i]); end
            checks++; if (lat != P || tg !== TAG_W'(i + 20)) begin failures++; $display("FAIL word_vec%0d_lat_tag got=%0d/%h exp=%0d/%h", i, lat, tg, P, TAG_W'(i + 20)); end
        end
        in_word = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
`ifdef YSYX_22040632_MUL_WORD_OP_EN
        in_word = 1'b0;
`endif
        test_reset();
        test_mul();
        test_high();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef YSYX_22040632_MUL_WORD_OP_EN
        test_word();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22040632_mul_wallace_pipe.md
Name: ysyx_22040632_mul_wallace_pipe

Overview:
Parametrised, pipelined signed/unsigned integer multiplier for the NPC EXU.
- Datapath: radix-4 Booth partial-product generation, then a Wallace tree of 3:2 carry-save adders per bit column with inter-column carries, then a final carry-propagate adder.
- Register boundaries are cut into a configurable number of pipeline stages.
- Valid/ready handshakes on both sides, a tag passthrough and a synchronous flush.
- Successor to the fixed 32-input column compressor: generalised in width, depth and mode.

Parameters:
WIDTH, 32, operand width; even, 8..64.
PIPE_STAGES, 2, register stages from accept to result; 1..4.
TAG_W, 5, width of opaque tag carried with each operation (e.g. rd index).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  request valid
in_ready  out  1  request can be accepted this cycle
in_op  in  2  00 MUL (low), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
in_a  in  WIDTH  multiplicand (rs1)
in_b  in  WIDTH  multiplier (rs2)
in_tag  in  TAG_W  tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  selected product half
out_tag  out  TAG_W  tag of the result

Behaviour:
- Accept: in_valid && in_ready at a rising edge.
- Extension: operands extended to WIDTH+2 bits per op.
  - Signed operand: sign-extended. Unsigned operand: zero-extended.
  - MUL extends both operands as signed; the low half is identical either way.
- Booth: WIDTH/2+1 partial products. Negation "+1" bits are injected as tree inputs, not as a separate adder.
- Tree and adder output: full 2*WIDTH product, modulo 2^(2*WIDTH). out_result = product[WIDTH-1:0] for MUL, product[2*WIDTH-1:WIDTH] otherwise.
- Stage cuts:
  - Stage 1 registers Booth PPs plus the first tree level.
  - Remaining tree levels are split as evenly as possible over stages 2..PIPE_STAGES.
  - The final CPA and half-select are in the last stage.
  - With PIPE_STAGES=1, the whole datapath sits before a single register.
- Per-stage valid bit. op and tag travel with data.
- Latency: an op accepted at edge N gives out_valid=1 after edge N+PIPE_STAGES, when not stalled. Throughput is 1 per cycle.
- Stall: global. stall = out_valid && !out_ready.
  - While stalled, no stage advances and out_result/out_tag are held stable.
  - in_ready = !stall && !flush.
- Bubbles are not compressed: a stall freezes empty stages too.
- Output transfer: out_valid && out_ready at an edge. The next stage's contents (or a bubble) advance the same edge.
- Flush: on an edge with flush=1, all valid bits clear.
  - in_ready=0 that cycle, so no op is accepted.
  - out_valid=0 from the next cycle. A result presented in the flush cycle counts as consumed only if out_ready=1.
- Reset: on an edge with rst=1, all valid bits clear and out_result=0, out_tag=0.
  - Mid-operation reset discards all in-flight ops.
  - rst has priority over flush and accept.
- Reset values: out_valid=0, out_result=0, out_tag=0. in_ready=1 after reset release.
- Data registers of invalid stages are don't-care, except the output registers, which hold their last value.

Optional Feature:
Macro YSYX_22040632_MUL_WORD_OP_EN (meaningful for WIDTH=64):
- Defined:
  - Adds port in_word (in, 1).
  - When 1, operands are the sign-extended low WIDTH/2 bits. Only op=00 is legal.
  - out_result = sign-extend(product[WIDTH/2-1:0]) to WIDTH (RV64 MULW).
  - The word flag travels with the op through the pipe.
- Undefined: the port is absent and all ops use the full width.

Test Plan:
1. WIDTH=32, PIPE_STAGES=2: accept MUL a=7, b=0xFFFFFFFD, tag=3 at edge N → out_valid=1 after edge N+2, out_result=0xFFFFFFEB, out_tag=3.
2. High halves with a=b=0x80000000: MULH → 0x40000000, MULHU → 0x40000000. With a=b=0xFFFFFFFF: MULHSU → 0xFFFFFFFF, MULHU → 0xFFFFFFFE, MULH → 0x00000000.
3. Back-to-back: tags 1,2,3 issued on consecutive cycles with out_ready=0 → in_ready drops once tag1 reaches the output. tag1 result stays stable for 5 held cycles. On raising out_ready, tags 1,2,3 emerge one per cycle in order.
4. Flush: two ops in flight, flush=1 for one cycle with in_valid=1 → that input is not accepted (in_ready=0) and out_valid stays 0 for the next PIPE_STAGES cycles. A new op issued after the flush returns correctly with latency 2.
5. Reset mid-operation: rst=1 one cycle while stage 1 is valid → out_valid=0, out_result=0, out_tag=0 next cycle, and no stale result ever appears.
6. WIDTH=64 with YSYX_22040632_MUL_WORD_OP_EN: in_word=1, a=0x00000000_00010000, b=0x00000000_00010000 → out_result=0x0000000000000000. With a=0x7FFFFFFF, b=2 → out_result=0xFFFFFFFFFFFFFFFE.
